// File: rtl/fta_credit_gate256.sv
// fta_credit_gate256
//   Credit-based request gate plus response FIFO sitting between an FTA
//   256-bit bus master and a fixed-latency, non-stalling slave.  The slave
//   cannot be back-pressured, so every ack-producing request must own a
//   FIFO slot before it is let through.
//
//   Ports
//     clk_i      clock
//     rst_i      asynchronous active-high reset
//     m_req      request from the master
//     m_stall_o  master must hold m_req (no credit left)
//     s_req      registered request toward the slave
//     s_resp     slave response, valid when ack=1
//     m_resp     FIFO head toward the master, ack=1 when not empty
//     m_pop_i    master consumes the FIFO head
//     ovf_o      sticky: an ack arrived without reservation or FIFO full

package fta_bus_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    FIXED   = 3'b001,
    INCR    = 3'b010,
    ERC     = 3'b111
  } fta_cycle_type_t;

  typedef enum logic [1:0] {
    OKAY    = 2'b00,
    DECERR  = 2'b01,
    PROTERR = 2'b10,
    ERR     = 2'b11
  } fta_tranerr_t;

  typedef struct packed {
    logic            cyc;
    logic            stb;
    logic            we;
    fta_cycle_type_t cti;
    logic [2:0]      pri;
    logic [7:0]      tid;
    logic [15:0]     asid;
    logic [31:0]     adr;
    logic [31:0]     sel;
    logic [255:0]    dat;
    logic            ctag;
  } fta_cmd_request256_t;

  typedef struct packed {
    logic         ack;
    logic         next;
    logic         stall;
    logic         rty;
    fta_tranerr_t err;
    logic [2:0]   pri;
    logic [7:0]   tid;
    logic [15:0]  asid;
    logic [31:0]  adr;
    logic [255:0] dat;
    logic         ctag;
  } fta_cmd_response256_t;

endpackage

module fta_credit_gate256
  import fta_bus_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  fta_cmd_request256_t  m_req,
  output logic                 m_stall_o,
  output fta_cmd_request256_t  s_req,
  input  fta_cmd_response256_t s_resp,
  output fta_cmd_response256_t m_resp,
  input  logic                 m_pop_i,
  output logic                 ovf_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [255:0] dat;
    logic [7:0]   tid;
    logic [15:0]  asid;
    logic [31:0]  adr;
    logic         ctag;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [CW-1:0] res;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic req_present;
  logic credit_req;
  logic accept;
  logic take_credit;
  logic pop;
  logic capture;
  logic unused_resp_bits;

  // Gate decisions.  The stall only looks at registered res, so a pop in
  // the same cycle cannot release it and m_pop_i never reaches m_stall_o.
  always_comb begin
    req_present = m_req.cyc & m_req.stb;
    credit_req  = ~m_req.we | (m_req.cti == ERC);
    m_stall_o   = req_present & credit_req & (res == FULL);
    accept      = req_present & ~m_stall_o;
    take_credit = accept & credit_req;
    pop         = m_pop_i & (cnt != '0);
    capture     = s_resp.ack & (cnt != FULL) & (res != '0);
  end

  assign unused_resp_bits = ^{s_resp.next, s_resp.stall, s_resp.rty,
                              s_resp.err, s_resp.pri};

  // Reservation and occupancy counters, FIFO pointers and the sticky
  // overflow flag.  An ack that finds no reservation or a full FIFO is
  // discarded rather than overwriting a live entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res    <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (take_credit && !pop) begin
        res <= res + CW'(1);
      end else if (!take_credit && pop) begin
        res <= res - CW'(1);
      end
      if (capture && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (!capture && pop) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (s_resp.ack && !capture) begin
        ovf_o <= 1'b1;
      end
    end
  end

  // Response storage; contents need no reset because cnt qualifies them.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      mem[wr_ptr] <= entry_t'{dat:  s_resp.dat,
                              tid:  s_resp.tid,
                              asid: s_resp.asid,
                              adr:  s_resp.adr,
                              ctag: s_resp.ctag};
    end
  end

  // Registered request toward the slave: one valid cycle per accept,
  // payload fields hold when idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_req <= '0;
    end else if (accept) begin
      s_req <= m_req;
    end else begin
      s_req.cyc <= 1'b0;
      s_req.stb <= 1'b0;
    end
  end

  // FIFO head presented to the master with fixed status fields.
  always_comb begin
    m_resp      = '0;
    m_resp.ack  = (cnt != '0);
    m_resp.err  = OKAY;
    m_resp.pri  = 3'd7;
    m_resp.dat  = mem[rd_ptr].dat;
    m_resp.tid  = mem[rd_ptr].tid;
    m_resp.asid = mem[rd_ptr].asid;
    m_resp.adr  = mem[rd_ptr].adr;
    m_resp.ctag = mem[rd_ptr].ctag;
  end

endmodule

// File: tb/tb_fta_credit_gate256.sv
// tb_fta_credit_gate256
//   Self-checking bench for fta_credit_gate256 with DEPTH=4 and a
//   three-stage fixed-latency slave model.  Expected responses are queued
//   when a credit-consuming request is accepted and compared against the
//   FIFO head; each scenario task adds its own targeted checks.

module tb_fta_credit_gate256;
  import fta_bus_pkg::*;

  localparam int DEPTH = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 m_pop_i = 1'b0;
  logic                 m_stall_o;
  logic                 ovf_o;
  fta_cmd_request256_t  m_req;
  fta_cmd_request256_t  s_req;
  fta_cmd_request256_t  idle_req;
  fta_cmd_response256_t s_resp;
  fta_cmd_response256_t m_resp;
  fta_cmd_response256_t sp0, sp1, sp2;
  fta_cmd_response256_t inj_resp;
  logic                 inj_en = 1'b0;

  int errors = 0;
  int checks = 0;

  fta_cmd_response256_t exp_q[$];
  int                   model_res = 0;
  int                   model_cnt = 0;
  logic                 model_ovf = 1'b0;
  logic [1:0]           model_wr = '0;
  logic [1:0]           model_rd = '0;
  logic                 exp_sreq_cyc = 1'b0;
  fta_cmd_request256_t  exp_sreq;

  fta_credit_gate256 #(.DEPTH(DEPTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .m_req     (m_req),
    .m_stall_o (m_stall_o),
    .s_req     (s_req),
    .s_resp    (s_resp),
    .m_resp    (m_resp),
    .m_pop_i   (m_pop_i),
    .ovf_o     (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic fta_cmd_request256_t mk_req(input logic we, input fta_cycle_type_t cti,
                                                 input logic [7:0] tid);
    fta_cmd_request256_t r;
    r      = '0;
    r.cyc  = 1'b1;
    r.stb  = 1'b1;
    r.we   = we;
    r.cti  = cti;
    r.pri  = 3'd2;
    r.tid  = tid;
    r.asid = 16'h00A0 + 16'(tid);
    r.adr  = 32'h0001_0000 | {19'd0, tid, 5'd0};
    r.sel  = '1;
    r.dat  = {32{tid}};
    r.ctag = tid[0];
    return r;
  endfunction

  // Slave behaviour: ack reads and ERC writes, echo ids, derive data.
  function automatic fta_cmd_response256_t slave_resp(input fta_cmd_request256_t q);
    fta_cmd_response256_t r;
    r      = '0;
    r.ack  = q.cyc & q.stb & (~q.we | (q.cti == ERC));
    r.err  = OKAY;
    r.pri  = 3'd1;
    r.tid  = q.tid;
    r.asid = q.asid;
    r.adr  = q.adr;
    r.dat  = {8{q.adr}} ^ {32{q.tid}};
    r.ctag = q.ctag;
    return r;
  endfunction

  function automatic fta_cmd_response256_t head_resp(input fta_cmd_request256_t q);
    fta_cmd_response256_t r;
    r     = slave_resp(q);
    r.ack = 1'b1;
    r.pri = 3'd7;
    return r;
  endfunction

  // Slave pipeline; never reset so in-flight acks survive a gate reset.
  always @(posedge clk_i) begin
    sp0 <= slave_resp(s_req);
    sp1 <= sp0;
    sp2 <= sp1;
  end

  always_comb begin
    s_resp = sp2;
    if (inj_en) s_resp = inj_resp;
  end

  // Scoreboard and cycle model, sampled on the falling edge.
  always @(negedge clk_i or posedge rst_i) begin
    logic credit, exp_stall, acc, pp, cap;
    if (rst_i) begin
      model_res    = 0;
      model_cnt    = 0;
      model_ovf    = 1'b0;
      model_wr     = '0;
      model_rd     = '0;
      exp_sreq_cyc = 1'b0;
      exp_q.delete();
    end else begin
      credit    = !m_req.we || (m_req.cti == ERC);
      exp_stall = m_req.cyc && m_req.stb && credit && (model_res == DEPTH);
      checks++;
      if (m_resp.ack !== (model_cnt != 0))
        begin errors++; $display("[TB] FAIL sb_ack got=%b want=%b", m_resp.ack, model_cnt != 0); end
      checks++;
      if (m_stall_o !== exp_stall)
        begin errors++; $display("[TB] FAIL sb_stall got=%b want=%b", m_stall_o, exp_stall); end
      checks++;
      if (ovf_o !== model_ovf)
        begin errors++; $display("[TB] FAIL sb_ovf got=%b want=%b", ovf_o, model_ovf); end
      checks++;
      if (exp_sreq_cyc) begin
        if (s_req !== exp_sreq)
          begin errors++; $display("[TB] FAIL sb_sreq got tid=%h we=%b cyc=%b want tid=%h we=%b cyc=1",
                                   s_req.tid, s_req.we, s_req.cyc, exp_sreq.tid, exp_sreq.we); end
      end else if (s_req.cyc !== 1'b0 || s_req.stb !== 1'b0) begin
        errors++; $display("[TB] FAIL sb_sreq_idle got cyc=%b stb=%b want 0", s_req.cyc, s_req.stb);
      end
      if (model_cnt != 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL sb_head got tid=%h want an empty queue entry", m_resp.tid);
        end else if (m_resp !== exp_q[0]) begin
          errors++; $display("[TB] FAIL sb_head got=%h want=%h", m_resp, exp_q[0]);
        end
      end
      acc = m_req.cyc && m_req.stb && !exp_stall;
      pp  = m_pop_i && (model_cnt != 0);
      cap = s_resp.ack && (model_cnt != DEPTH) && (model_res != 0);
      if (s_resp.ack && !cap) model_ovf = 1'b1;
      if (acc && credit) exp_q.push_back(head_resp(m_req));
      if (pp && exp_q.size() != 0) void'(exp_q.pop_front());
      model_res = model_res + ((acc && credit) ? 1 : 0) - (pp ? 1 : 0);
      model_cnt = model_cnt + (cap ? 1 : 0) - (pp ? 1 : 0);
      if (cap) model_wr = model_wr + 2'd1;
      if (pp)  model_rd = model_rd + 2'd1;
      exp_sreq_cyc = acc;
      if (acc) exp_sreq = m_req;
    end
  end

  task automatic applyStimulus(input fta_cmd_request256_t req, input logic pop);
    @(posedge clk_i);
    #1;
    m_req   = req;
    m_pop_i = pop;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (m_resp.ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack got=%b want=0", m_resp.ack); end
    checks++; if (m_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall got=%b want=0", m_stall_o); end
    checks++; if (s_req.cyc !== 1'b0 || s_req.stb !== 1'b0)
      begin errors++; $display("[TB] FAIL rst_sreq got cyc=%b stb=%b want 0", s_req.cyc, s_req.stb); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf got=%b want=0", ovf_o); end
    checks++; if (dut.res !== 3'd0 || dut.cnt !== 3'd0)
      begin errors++; $display("[TB] FAIL rst_counters got res=%0d cnt=%0d want 0", dut.res, dut.cnt); end
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    int n_sreq = 0;
    logic [7:0] seen[$];
    for (int c = 0; c < 16; c++) begin
      if (c < 4) applyStimulus(mk_req(1'b0, CLASSIC, 8'(c + 1)), 1'b1);
      else       applyStimulus(idle_req, 1'b1);
      @(negedge clk_i);
      if (s_req.cyc) n_sreq++;
      if (m_resp.ack) seen.push_back(m_resp.tid);
    end
    checks++; if (n_sreq != 4) begin errors++; $display("[TB] FAIL basic_sreq_cycles got=%0d want=4", n_sreq); end
    checks++; if (seen.size() != 4) begin errors++; $display("[TB] FAIL basic_ack_cycles got=%0d want=4", seen.size()); end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== 8'(i + 1)) begin errors++; $display("[TB] FAIL basic_order[%0d] got=%0d want=%0d", i, seen[i], i + 1); end
    end
    checks++; if (dut.res !== 3'd0) begin errors++; $display("[TB] FAIL basic_res got=%0d want=0", dut.res); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf got=%b want=0", ovf_o); end
  endtask

  task automatic test_stall();
    fta_cmd_request256_t r5;
    int   peak = 0;
    logic released = 1'b0;
    r5 = mk_req(1'b0, CLASSIC, 8'd15);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(mk_req(1'b0, CLASSIC, 8'(10 + i)), 1'b0);
      @(negedge clk_i);
    end
    applyStimulus(r5, 1'b0);
    @(negedge clk_i);
    checks++; if (m_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_fifth got=%b want=1", m_stall_o); end
    repeat (6) begin
      applyStimulus(r5, 1'b0);
      @(negedge clk_i);
      if (int'(dut.cnt) > peak) peak = int'(dut.cnt);
      if (!m_stall_o) released = 1'b1;
    end
    checks++; if (peak != 4) begin errors++; $display("[TB] FAIL stall_peak_cnt got=%0d want=4", peak); end
    checks++; if (released) begin errors++; $display("[TB] FAIL stall_held got=released want=stalled"); end
    applyStimulus(r5, 1'b1);
    @(negedge clk_i);
    checks++; if (m_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_pop_same_cycle got=%b want=1", m_stall_o); end
    applyStimulus(r5, 1'b0);
    @(negedge clk_i);
    checks++; if (m_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_after_pop got=%b want=0", m_stall_o); end
    applyStimulus(idle_req, 1'b0);
    @(negedge clk_i);
    checks++; if (s_req.cyc !== 1'b1 || s_req.tid !== 8'd15)
      begin errors++; $display("[TB] FAIL stall_fifth_issued got cyc=%b tid=%0d want 1/15", s_req.cyc, s_req.tid); end
    repeat (12) applyStimulus(idle_req, 1'b1);
    @(negedge clk_i);
    checks++; if (dut.cnt !== 3'd0 || dut.res !== 3'd0 || ovf_o !== 1'b0)
      begin errors++; $display("[TB] FAIL stall_drain got cnt=%0d res=%0d ovf=%b want 0/0/0", dut.cnt, dut.res, ovf_o); end
  endtask

  task automatic test_write_interleave();
    fta_cmd_request256_t seq[5];
    seq[0] = mk_req(1'b0, CLASSIC, 8'd21);
    seq[1] = mk_req(1'b0, CLASSIC, 8'd22);
    seq[2] = mk_req(1'b1, CLASSIC, 8'd9);
    seq[3] = mk_req(1'b0, CLASSIC, 8'd23);
    seq[4] = mk_req(1'b1, ERC, 8'd24);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(seq[i], 1'b0);
      @(negedge clk_i);
      checks++; if (m_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL wr_seq_stall[%0d] got=%b want=0", i, m_stall_o); end
    end
    applyStimulus(idle_req, 1'b0);
    @(negedge clk_i);
    checks++; if (dut.res !== 3'd4) begin errors++; $display("[TB] FAIL wr_res_full got=%0d want=4", dut.res); end
    applyStimulus(mk_req(1'b1, CLASSIC, 8'd10), 1'b0);
    @(negedge clk_i);
    checks++; if (m_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL wr_nonerc_stall got=%b want=0", m_stall_o); end
    applyStimulus(idle_req, 1'b0);
    @(negedge clk_i);
    checks++; if (s_req.cyc !== 1'b1 || s_req.we !== 1'b1 || s_req.tid !== 8'd10)
      begin errors++; $display("[TB] FAIL wr_sreq got cyc=%b we=%b tid=%0d want 1/1/10", s_req.cyc, s_req.we, s_req.tid); end
    checks++; if (dut.res !== 3'd4) begin errors++; $display("[TB] FAIL wr_no_credit got=%0d want=4", dut.res); end
    repeat (12) applyStimulus(idle_req, 1'b1);
    @(negedge clk_i);
    checks++; if (dut.res !== 3'd0 || dut.cnt !== 3'd0)
      begin errors++; $display("[TB] FAIL wr_drain got res=%0d cnt=%0d want 0/0", dut.res, dut.cnt); end
  endtask

  task automatic test_empty_pop();
    repeat (3) begin
      applyStimulus(idle_req, 1'b1);
      @(negedge clk_i);
      checks++; if (m_resp.ack !== 1'b0) begin errors++; $display("[TB] FAIL epop_ack got=%b want=0", m_resp.ack); end
    end
    applyStimulus(idle_req, 1'b0);
    @(negedge clk_i);
    checks++; if (dut.rd_ptr !== model_rd || dut.wr_ptr !== model_wr)
      begin errors++; $display("[TB] FAIL epop_ptrs got rd=%0d wr=%0d want rd=%0d wr=%0d", dut.rd_ptr, dut.wr_ptr, model_rd, model_wr); end
    checks++; if (dut.cnt !== 3'd0 || dut.res !== 3'd0)
      begin errors++; $display("[TB] FAIL epop_counters got cnt=%0d res=%0d want 0/0", dut.cnt, dut.res); end
  endtask

  task automatic test_unexpected_ack();
    applyStimulus(idle_req, 1'b0);
    inj_resp = slave_resp(mk_req(1'b0, CLASSIC, 8'h77));
    inj_en   = 1'b1;
    @(negedge clk_i);
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL uack_ovf_before got=%b want=0", ovf_o); end
    applyStimulus(idle_req, 1'b0);
    inj_en = 1'b0;
    @(negedge clk_i);
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("[TB] FAIL uack_ovf_set got=%b want=1", ovf_o); end
    checks++; if (m_resp.ack !== 1'b0 || dut.cnt !== 3'd0 || dut.wr_ptr !== model_wr)
      begin errors++; $display("[TB] FAIL uack_not_written got ack=%b cnt=%0d wr=%0d want 0/0/%0d", m_resp.ack, dut.cnt, dut.wr_ptr, model_wr); end
    repeat (3) begin
      applyStimulus(idle_req, 1'b1);
      @(negedge clk_i);
      checks++; if (ovf_o !== 1'b1) begin errors++; $display("[TB] FAIL uack_ovf_sticky got=%b want=1", ovf_o); end
    end
  endtask

  task automatic test_reset_midburst();
    logic got = 1'b0;
    applyStimulus(mk_req(1'b0, CLASSIC, 8'd31), 1'b1);
    applyStimulus(mk_req(1'b0, CLASSIC, 8'd32), 1'b1);
    applyStimulus(idle_req, 1'b1);
    applyStimulus(idle_req, 1'b1);
    rst_i = 1'b1;
    #1;
    checks++; if (m_resp.ack !== 1'b0 || m_stall_o !== 1'b0 || s_req.cyc !== 1'b0 || ovf_o !== 1'b0)
      begin errors++; $display("[TB] FAIL mrst_outputs got ack=%b stall=%b cyc=%b ovf=%b want 0", m_resp.ack, m_stall_o, s_req.cyc, ovf_o); end
    #1;
    rst_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(idle_req, 1'b1);
      @(negedge clk_i);
      if (c == 0) begin
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL mrst_ovf_early got=%b want=0", ovf_o); end
      end
      if (c == 1) begin
        checks++; if (ovf_o !== 1'b1) begin errors++; $display("[TB] FAIL mrst_ovf_late got=%b want=1", ovf_o); end
      end
      checks++; if (m_resp.ack !== 1'b0) begin errors++; $display("[TB] FAIL mrst_drop[%0d] got ack=%b want=0", c, m_resp.ack); end
    end
    applyStimulus(mk_req(1'b0, CLASSIC, 8'd33), 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (m_resp.ack && m_resp.tid == 8'd33) got = 1'b1;
      applyStimulus(idle_req, 1'b1);
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL mrst_next_read got=none want tid 33 within 12 cycles"); end
    checks++; if (dut.res !== 3'd0 || dut.cnt !== 3'd0)
      begin errors++; $display("[TB] FAIL mrst_final got res=%0d cnt=%0d want 0/0", dut.res, dut.cnt); end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired got=running want=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idle_req = '0;
    m_req    = '0;
    inj_resp = '0;
    test_reset();
    test_basic();
    test_stall();
    test_write_interleave();
    test_empty_pop();
    test_unexpected_ack();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fta_credit_gate256.md
# fta_credit_gate256

Credit-based request gate and response FIFO between an FTA 256-bit bus master and a fixed-latency, non-stalling slave such as the 256-bit scratch RAM. The slave never stalls and always returns its acks, so this block limits outstanding acked transactions to DEPTH. It registers each accepted request toward the slave and captures every slave ack into a FIFO. The master drains responses at its own rate with a pop strobe.

## Interface
Parameters:
- DEPTH, 8: response FIFO entries and maximum reserved transactions; must be a power of 2, at least 2.
- CW, $clog2(DEPTH)+1: counter width (derived; do not override).

Ports:
- clk_i  input  1  clock; one clock domain.
- rst_i  input  1  reset; asynchronous, active-high.
- m_req  input  fta_cmd_request256_t  request from the master.
- m_stall_o  output  1  master must hold m_req this cycle; request not accepted.
- s_req  output  fta_cmd_request256_t  registered request to the slave.
- s_resp  input  fta_cmd_response256_t  response from the slave; valid when ack=1.
- m_resp  output  fta_cmd_response256_t  FIFO head; ack=1 means the FIFO is not empty.
- m_pop_i  input  1  master consumes the head this cycle.
- ovf_o  output  1  sticky error: an ack arrived with no reservation or with the FIFO full.

## Operation
- Request present: m_req.cyc & m_req.stb.
- Credit-consuming request: a read (we=0), or a write with cti==ERC. A non-ERC write produces no ack and consumes no credit.
- Reservation counter `res` (CW bits):
  - +1 when a credit-consuming request is accepted.
  - −1 on each effective pop.
  - Both in the same cycle: res unchanged.
- FIFO occupancy `cnt` (CW bits):
  - +1 on each captured ack.
  - −1 on each effective pop.
  - Both in the same cycle: cnt unchanged.
- m_stall_o is combinational from registered state: 1 when the request is present, credit-consuming, and res==DEPTH; otherwise 0.
  - A pop in the same cycle does not release the stall; no combinational path from m_pop_i to m_stall_o.
- Accepted request: s_req is loaded with m_req on the next edge, all fields copied.
- No accepted request, or a stalled one: s_req.cyc and s_req.stb load 0; other fields hold.
- Capture: on s_resp.ack, write {dat, tid, asid, adr, ctag} at the write pointer; the write pointer advances modulo DEPTH.
  - If cnt==DEPTH, or res==0, the ack is dropped and ovf_o sets.
  - ovf_o clears only on reset.
- Output:
  - m_resp.ack = (cnt!=0).
  - dat, tid, asid, adr and ctag come from the entry at the read pointer.
  - next, stall and rty are 0; err is OKAY; pri is 7.
- Effective pop is m_pop_i & (cnt!=0); the read pointer advances modulo DEPTH. A pop while empty is ignored and changes no state.
- Invariant: cnt ≤ res ≤ DEPTH. A legal slave therefore cannot overflow the FIFO.

## Timing
- Reset values (asynchronous):
  - res=0, cnt=0, both pointers=0, ovf_o=0.
  - s_req.cyc=0, s_req.stb=0.
  - m_resp.ack=0, m_stall_o=0.
- Request accepted at edge N: s_req is valid during cycle N+1, for exactly one cycle per accept.
- Throughput: one accept per cycle.
- Ack sampled at edge K: m_resp.ack is 1 during cycle K+1. Total read latency is slave latency + 2.
- Pop at edge P: the next entry is visible during cycle P+1. Back-to-back pops drain one entry per cycle.
- Ack and pop at the same edge with cnt==DEPTH: the ack is dropped, ovf_o=1, the pop proceeds.
- Reset mid-operation: acks still in flight from the slave arrive with res==0. They are dropped and set ovf_o. The bench must expect this.

## Test plan
- DEPTH=4, slave latency 3, four reads tid 1..4 on consecutive cycles, m_pop_i held 1 -> s_req.cyc high for 4 cycles; m_resp.ack high 4 cycles in tid order 1,2,3,4; res returns to 0; ovf_o=0.
- Five reads with m_pop_i=0 -> fifth stalls (m_stall_o=1) while res==4; one pop -> fifth accepted on the following edge; cnt peaks at 4; no drop.
- Interleave one non-ERC write with three reads while res==4 -> the write is accepted without stall; it consumes no credit; s_req shows we=1 for that write.
- Inject an ack with res==0 -> the entry is not written; cnt stays 0; ovf_o=1 from the next cycle until reset.
- Pop with cnt==0 -> pointers, cnt and res unchanged; m_resp.ack stays 0.
- Assert rst_i mid-burst with two reads in flight -> all outputs take reset values immediately; the two late acks are dropped; ovf_o=1 after the first late ack; the next read after release completes normally.
